// File: rtl/activation_scheduler.sv
// Time-multiplexes one activation unit across a row of requantized accumulators.
// Define ACT_SCHED_SAT_CNT_EN to add the saturation counter ports.
module activation_scheduler #(
    parameter int NUM_COLS   = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_SHIFT = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [1:0]                     cfg_activ_type_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_COLS*ACC_WIDTH-1:0]  in_acc_i,
    output logic [1:0]                     act_type_o,
    output logic [DATA_WIDTH-1:0]          act_z_o,
    input  logic [DATA_WIDTH-1:0]          act_y_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_COLS*DATA_WIDTH-1:0] out_data_o,
    output logic                           busy_o
`ifdef ACT_SCHED_SAT_CNT_EN
    ,
    input  logic                           sat_clr_i,
    output logic [15:0]                    sat_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_e;

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COLS - 1);
    localparam logic [1:0] T_BYPASS = 2'd3;
    localparam logic signed [ACC_WIDTH-1:0] Q_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] Q_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              type_q, type_d;
    logic [ACC_WIDTH-1:0]    acc_q [NUM_COLS];
    logic [ACC_WIDTH-1:0]    acc_d [NUM_COLS];
    logic [DATA_WIDTH-1:0]   obuf_q [NUM_COLS];
    logic [DATA_WIDTH-1:0]   obuf_d [NUM_COLS];

    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        sat_hi, sat_lo;
    logic [DATA_WIDTH-1:0]       quant;
    logic                        run, accept;

    always_comb begin
        shifted = $signed(acc_q[idx_q]) >>> FRAC_SHIFT;
        sat_hi  = shifted > Q_MAX;
        sat_lo  = shifted < Q_MIN;
        quant   = shifted[DATA_WIDTH-1:0];
        if (sat_hi) begin
            quant = Q_MAX[DATA_WIDTH-1:0];
        end else if (sat_lo) begin
            quant = Q_MIN[DATA_WIDTH-1:0];
        end
    end

    assign run         = (state_q == S_RUN);
    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q != S_IDLE);
    assign act_z_o     = run ? quant : '0;
    // Bypass rows keep the unit on a defined selector
    assign act_type_o  = (run && type_q != T_BYPASS) ? type_q : 2'd0;

    always_comb begin
        out_data_o = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            out_data_o[k*DATA_WIDTH +: DATA_WIDTH] = obuf_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        type_d  = type_q;
        acc_d   = acc_q;
        obuf_d  = obuf_q;
        unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                obuf_d[idx_q] = (type_q == T_BYPASS) ? quant : act_y_i;
                if (idx_q == LAST) begin
                    state_d = S_OUT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_RUN;
            idx_d   = '0;
            type_d  = cfg_activ_type_i;
            for (int k = 0; k < NUM_COLS; k++) begin
                acc_d[k] = in_acc_i[k*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            type_q  <= '0;
            for (int k = 0; k < NUM_COLS; k++) begin
                acc_q[k]  <= '0;
                obuf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            acc_q   <= acc_d;
            obuf_q  <= obuf_d;
        end
    end

`ifdef ACT_SCHED_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (run && (sat_hi || sat_lo) && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count_o = sat_cnt_q;
`endif

endmodule
